mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes EX results through, or issues one data-memory
// request per load/store and stalls upstream until the memory acknowledges it.
module mem_access_stage #(
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid_in,
  input  logic                branch_taken_in,
  input  logic [4:0]          rdn_in,
  input  logic [WordSize-1:0] pc_in,
  input  logic [WordSize-1:0] branch_addr_in,
  input  logic [WordSize-1:0] rs2d_in,
  input  logic [WordSize-1:0] alu_out_in,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WordSize-1:0] dmem_addr,
  output logic [WordSize-1:0] dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ack,
  input  logic [WordSize-1:0] dmem_rdata,
  output logic                valid_out,
  output logic                branch_taken,
  output logic                misalign,
  output logic [4:0]          rdn,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] branch_addr,
  output logic [WordSize-1:0] wb_data
);

  localparam int unsigned BeW  = 4;
  localparam int unsigned RegW = 5;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [WordSize-1:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
  logic [WordSize-1:0] req_pc_q, req_pc_d, req_baddr_q, req_baddr_d;
  logic [1:0]          req_size_q, req_size_d;
  logic                req_uns_q, req_uns_d, req_we_q, req_we_d, req_bt_q, req_bt_d;
  logic [RegW-1:0]     req_rdn_q, req_rdn_d;
  logic [BeW-1:0]      req_be_q, req_be_d;

  logic                valid_out_d, branch_taken_d, misalign_d;
  logic [RegW-1:0]     rdn_d;
  logic [WordSize-1:0] pc_d, branch_addr_d, wb_data_d;

  logic                aligned_c;
  logic [BeW-1:0]      be_c;
  logic [WordSize-1:0] wdata_c, load_data_c;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;

  // Memory interface is driven straight from the captured request while in ACCESS
  assign stall      = (state_q == ACCESS);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = (state_q == ACCESS) && req_we_q;
  assign dmem_be    = (state_q == ACCESS) ? req_be_q : '0;
  assign dmem_addr  = {req_addr_q[WordSize-1:2], 2'b00};
  assign dmem_wdata = req_wdata_q;

  // Alignment, byte enables and replicated store data for the incoming op
  always_comb begin
    aligned_c = 1'b1;
    be_c      = 4'b1111;
    wdata_c   = rs2d_in;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << alu_out_in[1:0];
        wdata_c = WordSize'({4{rs2d_in[7:0]}});
      end
      2'b01: begin
        aligned_c = ~alu_out_in[0];
        be_c      = alu_out_in[1] ? 4'b1100 : 4'b0011;
        wdata_c   = WordSize'({2{rs2d_in[15:0]}});
      end
      default: aligned_c = (alu_out_in[1:0] == 2'b00);
    endcase
  end

  // Lane select and extension of returning load data
  always_comb begin
    lane_h = req_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (req_addr_q[1:0])
      2'b00:   lane_b = dmem_rdata[7:0];
      2'b01:   lane_b = dmem_rdata[15:8];
      2'b10:   lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    if (req_size_q[1])
      load_data_c = dmem_rdata;
    else if (req_size_q[0])
      load_data_c = req_uns_q ? WordSize'(lane_h) : {{(WordSize-16){lane_h[15]}}, lane_h};
    else
      load_data_c = req_uns_q ? WordSize'(lane_b) : {{(WordSize-8){lane_b[7]}}, lane_b};
  end

  // Next-state and register-update logic
  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_pc_d       = req_pc_q;
    req_baddr_d    = req_baddr_q;
    req_size_d     = req_size_q;
    req_uns_d      = req_uns_q;
    req_we_d       = req_we_q;
    req_bt_d       = req_bt_q;
    req_rdn_d      = req_rdn_q;
    req_be_d       = req_be_q;
    valid_out_d    = valid_out;
    branch_taken_d = branch_taken;
    misalign_d     = misalign;
    rdn_d          = rdn;
    pc_d           = pc;
    branch_addr_d  = branch_addr;
    wb_data_d      = wb_data;

    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          valid_out_d    = 1'b0;
          branch_taken_d = 1'b0;
        end else if (!(mem_rd || mem_wr) || !aligned_c) begin
          // Pass-through ALU result, or a misaligned op reported without a request
          valid_out_d    = 1'b1;
          misalign_d     = mem_rd || mem_wr;
          rdn_d          = (mem_rd || mem_wr) ? '0 : rdn_in;
          pc_d           = pc_in;
          branch_addr_d  = branch_addr_in;
          branch_taken_d = branch_taken_in;
          wb_data_d      = alu_out_in;
        end else begin
          req_addr_d     = alu_out_in;
          req_wdata_d    = wdata_c;
          req_be_d       = be_c;
          req_size_d     = mem_size;
          req_uns_d      = mem_unsigned;
          req_we_d       = mem_wr;
          req_rdn_d      = rdn_in;
          req_pc_d       = pc_in;
          req_baddr_d    = branch_addr_in;
          req_bt_d       = branch_taken_in;
          valid_out_d    = 1'b0;
          branch_taken_d = 1'b0;
          state_d        = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          valid_out_d    = 1'b1;
          misalign_d     = 1'b0;
          rdn_d          = req_we_q ? '0 : req_rdn_q;
          pc_d           = req_pc_q;
          branch_addr_d  = req_baddr_q;
          branch_taken_d = req_bt_q;
          wb_data_d      = req_we_q ? req_addr_q : load_data_c;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_pc_q     <= '0;
      req_baddr_q  <= '0;
      req_size_q   <= '0;
      req_uns_q    <= 1'b0;
      req_we_q     <= 1'b0;
      req_bt_q     <= 1'b0;
      req_rdn_q    <= '0;
      req_be_q     <= '0;
      valid_out    <= 1'b0;
      branch_taken <= 1'b0;
      misalign     <= 1'b0;
      rdn          <= '0;
      pc           <= '0;
      branch_addr  <= '0;
      wb_data      <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_pc_q     <= req_pc_d;
      req_baddr_q  <= req_baddr_d;
      req_size_q   <= req_size_d;
      req_uns_q    <= req_uns_d;
      req_we_q     <= req_we_d;
      req_bt_q     <= req_bt_d;
      req_rdn_q    <= req_rdn_d;
      req_be_q     <= req_be_d;
      valid_out    <= valid_out_d;
      branch_taken <= branch_taken_d;
      misalign     <= misalign_d;
      rdn          <= rdn_d;
      pc           <= pc_d;
      branch_addr  <= branch_addr_d;
      wb_data      <= wb_data_d;
    end
  end

endmodule
